// File: rtl/hdp_config_sequencer.sv
// ---------------------------------------------------------------------------
// hdp_config_sequencer
//
// Walks an external init-table ROM of (address, data) pairs and issues one
// SPI register write per entry to the HDP SPI master, waiting for each write
// to complete and then idling for a programmable gap before the next entry.
// An entry whose address is 7'h7F terminates the walk early.
//
// Optional feature macro: SEQ_READBACK_VERIFY_EN
//   When defined, every write is followed by a readback of the same address.
//   A readback mismatch raises o_error, records the entry in o_errorIndex and
//   ends the sequence. When undefined, the read path is absent and
//   o_rxBegin, o_rxAddress, o_error and o_errorIndex are tied to 0.
//
// Ports:
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_start                 start request, honoured only while idle
//   o_busy, o_done          sequence in progress / one-cycle completion pulse
//   o_error, o_errorIndex   sticky readback failure flag and failing entry
//   o_romIndex              table read index
//   i_romAddress, i_romData table contents, one cycle after o_romIndex
//   o_txBegin/Address/Data  write request to the SPI master
//   i_txBusy, i_txDone      SPI write status
//   o_rxBegin, o_rxAddress  read request to the SPI master
//   i_rxData, i_rxBusy, i_rxDone  SPI read status and result
// ---------------------------------------------------------------------------
module hdp_config_sequencer #(
   parameter int INDEX_WIDTH = 4,
   parameter int NUM_ENTRIES = 16,
   parameter int GAP_CYCLES  = 100
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_error,
   output logic [INDEX_WIDTH-1:0] o_errorIndex,
   output logic [INDEX_WIDTH-1:0] o_romIndex,
   input  logic [6:0]             i_romAddress,
   input  logic [7:0]             i_romData,
   output logic                   o_txBegin,
   output logic [6:0]             o_txAddress,
   output logic [7:0]             o_txData,
   input  logic                   i_txBusy,
   input  logic                   i_txDone,
   output logic                   o_rxBegin,
   output logic [6:0]             o_rxAddress,
   input  logic [7:0]             i_rxData,
   input  logic                   i_rxBusy,
   input  logic                   i_rxDone
);

   localparam int GAP_WIDTH = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_WIDTH-1:0]   GAP_LAST   = GAP_WIDTH'(GAP_CYCLES - 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_ENTRIES - 1);
   localparam logic [6:0]             TERMINATOR = 7'h7F;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT_TX,
`ifdef SEQ_READBACK_VERIFY_EN
      ISSUE_RX,
      WAIT_RX,
`endif
      GAP,
      DONE
   } state_t;

   state_t                 state_reg, state_next;
   logic [INDEX_WIDTH-1:0] index_reg, index_next;
   // FETCH spans two cycles: phase 0 presents the index to the registered
   // ROM, phase 1 sees the ROM output and captures it.
   logic                   phase_reg, phase_next;
   logic [6:0]             address_reg, address_next;
   logic [7:0]             data_reg, data_next;
   logic [GAP_WIDTH-1:0]   gap_count_reg, gap_count_next;
   logic                   tx_begin;
   logic                   spi_idle;

`ifdef SEQ_READBACK_VERIFY_EN
   logic                   error_reg, error_next;
   logic [INDEX_WIDTH-1:0] error_index_reg, error_index_next;
   logic                   rx_begin;
`endif

   // The SPI master is not reset with us, so a transfer started before our
   // reset may still be running; never issue a request on top of it.
   assign spi_idle = !(i_txBusy || i_rxBusy);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_reg       <= IDLE;
         index_reg       <= '0;
         phase_reg       <= 1'b0;
         address_reg     <= '0;
         data_reg        <= '0;
         gap_count_reg   <= '0;
`ifdef SEQ_READBACK_VERIFY_EN
         error_reg       <= 1'b0;
         error_index_reg <= '0;
`endif
      end else begin
         state_reg       <= state_next;
         index_reg       <= index_next;
         phase_reg       <= phase_next;
         address_reg     <= address_next;
         data_reg        <= data_next;
         gap_count_reg   <= gap_count_next;
`ifdef SEQ_READBACK_VERIFY_EN
         error_reg       <= error_next;
         error_index_reg <= error_index_next;
`endif
      end
   end

   always_comb begin
      state_next       = state_reg;
      index_next       = index_reg;
      phase_next       = phase_reg;
      address_next     = address_reg;
      data_next        = data_reg;
      gap_count_next   = gap_count_reg;
      tx_begin         = 1'b0;
`ifdef SEQ_READBACK_VERIFY_EN
      error_next       = error_reg;
      error_index_next = error_index_reg;
      rx_begin         = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               state_next       = FETCH;
               index_next       = '0;
               phase_next       = 1'b0;
`ifdef SEQ_READBACK_VERIFY_EN
               error_next       = 1'b0;
               error_index_next = '0;
`endif
            end
         end
         FETCH: begin
            if (!phase_reg) begin
               phase_next = 1'b1;
            end else begin
               phase_next = 1'b0;
               if (i_romAddress == TERMINATOR) begin
                  state_next = DONE;
               end else begin
                  address_next = i_romAddress;
                  data_next    = i_romData;
                  state_next   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (spi_idle) begin
               tx_begin   = 1'b1;
               state_next = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (i_txDone) begin
               gap_count_next = '0;
`ifdef SEQ_READBACK_VERIFY_EN
               state_next     = ISSUE_RX;
`else
               state_next     = GAP;
`endif
            end
         end
`ifdef SEQ_READBACK_VERIFY_EN
         ISSUE_RX: begin
            if (spi_idle) begin
               rx_begin   = 1'b1;
               state_next = WAIT_RX;
            end
         end
         WAIT_RX: begin
            if (i_rxDone) begin
               if (i_rxData == data_reg) begin
                  state_next = GAP;
               end else begin
                  error_next       = 1'b1;
                  error_index_next = index_reg;
                  state_next       = DONE;
               end
            end
         end
`endif
         GAP: begin
            if (gap_count_reg == GAP_LAST) begin
               gap_count_next = '0;
               // Compare before incrementing so a full-depth table ends on
               // its last entry instead of wrapping back to 0.
               if (index_reg == LAST_INDEX) begin
                  state_next = DONE;
               end else begin
                  index_next = index_reg + INDEX_WIDTH'(1);
                  phase_next = 1'b0;
                  state_next = FETCH;
               end
            end else begin
               gap_count_next = gap_count_reg + GAP_WIDTH'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign o_busy      = (state_reg != IDLE);
   assign o_done      = (state_reg == DONE);
   assign o_romIndex  = index_reg;
   assign o_txBegin   = tx_begin;
   assign o_txAddress = address_reg;
   assign o_txData    = data_reg;

`ifdef SEQ_READBACK_VERIFY_EN
   assign o_rxBegin    = rx_begin;
   assign o_rxAddress  = address_reg;
   assign o_error      = error_reg;
   assign o_errorIndex = error_index_reg;
`else
   assign o_rxBegin    = 1'b0;
   assign o_rxAddress  = '0;
   assign o_error      = 1'b0;
   assign o_errorIndex = '0;

   // Read result inputs have no consumer without readback.
   logic unused_rx;
   assign unused_rx = ^{i_rxData, i_rxDone};
`endif

endmodule
